data_cache: RTL and testbench

Direct-mapped, write-through, word-granular data cache between the CPU memory stage and the backing data memory. It serves load hits combinationally in the memory-stage cycle. It stalls the pipeline through a handshake with the backing memory on load misses and on every store. Its `stall` output feeds the hazard unit, which freezes all pipeline stages while it is high.

---
 rtl/data_cache.sv | 163 ++++++++++++++++
 tb/tb_data_cache.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, word-granular data cache for the memory stage.
// Load hits resolve combinationally; load misses and all stores stall through a backing-memory handshake.
module data_cache #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_WIDTH   = 3,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic [COUNT_WIDTH-1:0]   hit_count,
  output logic [COUNT_WIDTH-1:0]   miss_count
);

  // state | meaning
  // IDLE  | serve hits, launch fills on load miss, launch writes on store
  // FILL  | backing-memory read outstanding for the latched address
  // WRITE | backing-memory write outstanding for the latched address/data
  // DONE  | store retires; request present this cycle is ignored

  localparam int LINES  = 1 << INDEX_WIDTH;
  localparam int TAG_W  = ADDRESS_WIDTH - INDEX_WIDTH - 2;
  localparam int WORD_W = ADDRESS_WIDTH - 2;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [DATA_WIDTH-1:0]   data_q [LINES];
  logic [WORD_W-1:0]       req_word_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;
  logic [COUNT_WIDTH-1:0]  hit_q, miss_q;

  logic [INDEX_WIDTH-1:0]  cpu_idx, req_idx;
  logic [TAG_W-1:0]        cpu_tag, req_tag;
  logic                    cpu_hit, req_hit;
  logic                    latch_en, latch_wdata;
  logic                    hit_inc, miss_inc;
  logic                    line_fill, line_upd;
  logic                    addr_lsb_unused;

  assign addr_lsb_unused = ^cpu_addr[1:0];

  assign cpu_idx = cpu_addr[INDEX_WIDTH+1:2];
  assign cpu_tag = cpu_addr[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  assign req_idx = req_word_q[INDEX_WIDTH-1:0];
  assign req_tag = req_word_q[WORD_W-1:INDEX_WIDTH];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Memory-side outputs depend only on registered state so they hold steady until ack.
  assign mem_req   = (state_q == S_FILL) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = {req_word_q, 2'b00};
  assign mem_wdata = req_wdata_q;

  assign cpu_rdata  = data_q[cpu_idx];
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    latch_en    = 1'b0;
    latch_wdata = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    line_fill   = 1'b0;
    line_upd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_we) begin
          latch_en    = 1'b1;
          latch_wdata = 1'b1;
          stall       = 1'b1;
          state_d     = S_WRITE;
        end else if (cpu_re) begin
          if (cpu_hit) begin
            hit_inc = 1'b1;
          end else begin
            latch_en = 1'b1;
            stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = S_FILL;
          end
        end
      end
      S_FILL: begin
        stall = 1'b1;
        if (mem_ack) begin
          line_fill = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WRITE: begin
        stall = 1'b1;
        if (mem_ack) begin
          // write-update only; a store miss never allocates
          line_upd = req_hit;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        req_word_q <= cpu_addr[ADDRESS_WIDTH-1:2];
      end
      if (latch_wdata) begin
        req_wdata_q <= cpu_wdata;
      end
      if (line_fill) begin
        valid_q[req_idx] <= 1'b1;
        tag_q[req_idx]   <= req_tag;
        data_q[req_idx]  <= mem_rdata;
      end else if (line_upd) begin
        data_q[req_idx] <= req_wdata_q;
      end
      if (hit_inc && (hit_q != '1)) begin
        hit_q <= hit_q + CNT_ONE;
      end
      if (miss_inc && (miss_q != '1)) begin
        miss_q <= miss_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus queues expected load data and memory transactions,
// independent monitors pop and compare when the DUT completes a load or a memory handshake.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  hit_count, miss_count;

  data_cache #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .INDEX_WIDTH(3), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } mem_exp_t;

  logic [31:0] load_q [$];
  mem_exp_t    mem_q  [$];
  logic [31:0] mem_model [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int ack_delay = 0;
  bit late_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Backing memory: ack arrives ack_delay cycles after mem_req rises.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        if (cnt == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Load monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cpu_re && !cpu_we && !stall) begin
        if (load_q.size() == 0) begin
          chk("unexpected_load_done", cpu_rdata, 32'hxxxx_xxxx);
        end else begin
          logic [31:0] e;
          e = load_q.pop_front();
          chk("load_rdata", cpu_rdata, e);
        end
      end
    end
  end

  // Memory transaction monitor
  initial begin
    int req_cycles;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      else req_cycles = 0;
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_txn", mem_addr, 32'hxxxx_xxxx);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_req_cycles", req_cycles, e.cycles);
        end
      end
    end
  end

  task automatic wait_unstall(input string nm, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n >= 100) begin
        chk({nm, "_timeout"}, 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input bit miss, input int dly);
    int n;
    load_q.push_back(exp);
    if (miss) mem_q.push_back('{1'b0, a, 32'h0, dly + 1});
    ack_delay = dly;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    wait_unstall("load", n);
    if (!miss) chk("hit_stall_cycles", 32'(n), 32'd0);
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int dly);
    int n;
    mem_q.push_back('{1'b1, a, d, dly + 1});
    ack_delay = dly;
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_wdata = d;
    wait_unstall("store", n);
    chk("done_stall", {31'b0, stall}, 32'd0);
    chk("done_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  initial begin
    mem_model[32'h100] = 32'hDEADBEEF;
    mem_model[32'h120] = 32'h0BADF00D;
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_hit_count", {28'b0, hit_count}, 32'd0);
    chk("rst_miss_count", {28'b0, miss_count}, 32'd0);
    rst = 1'b0;

    do_load(32'h100, 32'hDEADBEEF, 1'b1, 2);
    chk("miss_cnt_a", {28'b0, miss_count}, 32'd1);
    chk("hit_cnt_a", {28'b0, hit_count}, 32'd1);
    do_load(32'h100, 32'hDEADBEEF, 1'b0, 0);
    chk("hit_cnt_b", {28'b0, hit_count}, 32'd2);

    do_store(32'h100, 32'h12345678, 1);
    do_load(32'h100, 32'h12345678, 1'b0, 0);
    chk("hit_cnt_c", {28'b0, hit_count}, 32'd3);

    do_store(32'h200, 32'hCAFEF00D, 0);
    do_load(32'h200, 32'hCAFEF00D, 1'b1, 0);
    chk("miss_cnt_d", {28'b0, miss_count}, 32'd2);

    do_load(32'h100, 32'h12345678, 1'b1, 1);
    do_load(32'h120, 32'h0BADF00D, 1'b1, 3);
    do_load(32'h100, 32'h12345678, 1'b1, 0);
    chk("miss_cnt_e", {28'b0, miss_count}, 32'd5);
    chk("hit_cnt_e", {28'b0, hit_count}, 32'd7);

    for (int i = 0; i < 10; i++) do_load(32'h100, 32'h12345678, 1'b0, 0);
    chk("hit_cnt_sat", {28'b0, hit_count}, 32'd15);
    chk("miss_cnt_sat", {28'b0, miss_count}, 32'd5);

    // Reset in the middle of a fill
    ack_delay = 20;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 32'h10C;
    repeat (3) @(posedge clk);
    #1;
    chk("fill_mem_req", {31'b0, mem_req}, 32'd1);
    cpu_re = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_hit_count", {28'b0, hit_count}, 32'd0);
    chk("abort_miss_count", {28'b0, miss_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    late_ack = 1'b1;
    @(posedge clk); #5;
    late_ack = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall}, 32'd0);
    chk("late_ack_miss_count", {28'b0, miss_count}, 32'd0);
    do_load(32'h100, 32'h12345678, 1'b1, 1);
    chk("post_rst_miss_count", {28'b0, miss_count}, 32'd1);
    chk("post_rst_hit_count", {28'b0, hit_count}, 32'd1);

    repeat (3) @(posedge clk);
    chk("load_queue_drained", 32'(load_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
